// File: rtl/bip_pkg.sv
// BIP shared definitions: dump FSM state encoding and default data-memory widths.
// Latency: n/a (package only).
// Backpressure: n/a.
package bip_pkg;

  localparam int NB_DATA_DEF          = 16;
  localparam int N_DATA_ADDR_DEF      = 1024;
  localparam int LOG2_N_DATA_ADDR_DEF = 10;

  // Dump engine states; 2-bit encoding shared with bip_cpu's debug view.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_t;

  // Any non-idle state owns the RAM port and locks out the CPU.
  function automatic logic is_busy(input dump_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/bip_dmem_array.sv
// Single-port synchronous RAM with a registered, enabled read port.
// Latency: read data 1 cycle after rd_en; rd_data holds when rd_en is low.
// Backpressure: none. Optional macro BIP_DMEM_WR_FIRST_EN selects write-first reads.
module bip_dmem_array
  import bip_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int N_WORDS = N_DATA_ADDR_DEF,
  parameter int AW      = LOG2_N_DATA_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [AW-1:0]      addr,
  input  logic [NB_DATA-1:0] wr_data,
  output logic [NB_DATA-1:0] rd_data
);

  logic [NB_DATA-1:0] mem [N_WORDS];

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

  // Registered read; holds between reads so consumers can stall on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
`ifdef BIP_DMEM_WR_FIRST_EN
      rd_data <= wr_en ? wr_data : mem[addr];
`else
      rd_data <= mem[addr];
`endif
    end
  end

endmodule

// File: rtl/bip_data_mem.sv
// BIP data memory: CPU ld/st responder plus a post-run dump streamer (valid/ready).
// Latency: CPU read data 1 cycle after strobe; dump at best one word per 2 cycles.
// Backpressure: dump stalls in SEND while i_dump_ready is low; CPU port ignored while busy.
// Optional macro BIP_DMEM_WR_FIRST_EN: same-cycle rd&wr returns the new write data.
module bip_data_mem
  import bip_pkg::*;
#(
  parameter int NB_DATA          = NB_DATA_DEF,
  parameter int N_DATA_ADDR      = N_DATA_ADDR_DEF,
  parameter int LOG2_N_DATA_ADDR = LOG2_N_DATA_ADDR_DEF,
  parameter int DUMP_DEPTH       = N_DATA_ADDR_DEF
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic                        i_rd_ram,
  input  logic                        i_wr_ram,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0]          i_data,
  output logic [NB_DATA-1:0]          o_data_mem,
  input  logic                        i_dump_start,
  input  logic                        i_dump_ready,
  output logic                        o_dump_valid,
  output logic [LOG2_N_DATA_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0]          o_dump_data,
  output logic                        o_dump_done,
  output logic                        o_busy
);

  localparam logic [LOG2_N_DATA_ADDR-1:0] LAST_PTR = LOG2_N_DATA_ADDR'(DUMP_DEPTH - 1);

  dump_state_t                 state, state_next;
  logic [LOG2_N_DATA_ADDR-1:0] ptr;
  logic                        cpu_go;
  logic                        cpu_rd_d;
  logic [NB_DATA-1:0]          cpu_hold;
  logic                        ram_rd_en, ram_wr_en;
  logic [LOG2_N_DATA_ADDR-1:0] ram_addr;
  logic [NB_DATA-1:0]          ram_rdata;

  assign cpu_go = (state == ST_IDLE) && i_valid;

  // RAM port arbitration: dump pointer owns the port whenever the engine is active.
  always_comb begin
    ram_addr  = i_addr;
    ram_rd_en = cpu_go && i_rd_ram;
    ram_wr_en = cpu_go && i_wr_ram;
    if (is_busy(state)) begin
      ram_addr  = ptr;
      ram_rd_en = (state == ST_RD);
      ram_wr_en = 1'b0;
    end
  end

  bip_dmem_array #(
    .NB_DATA (NB_DATA),
    .N_WORDS (N_DATA_ADDR),
    .AW      (LOG2_N_DATA_ADDR)
  ) u_array (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .rd_en   (ram_rd_en),
    .wr_en   (ram_wr_en),
    .addr    (ram_addr),
    .wr_data (i_data),
    .rd_data (ram_rdata)
  );

  // Dump FSM state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Dump FSM next state: one RD/SEND pair per word, DONE after the last handshake.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (i_dump_start) state_next = ST_RD;
      ST_RD:   state_next = ST_SEND;
      ST_SEND: if (i_dump_ready) state_next = (ptr == LAST_PTR) ? ST_DONE : ST_RD;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Dump pointer: advances on each accepted word, never wraps, cleared in DONE.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ptr <= '0;
    end else if (state == ST_DONE) begin
      ptr <= '0;
    end else if (state == ST_SEND && i_dump_ready && ptr != LAST_PTR) begin
      ptr <= ptr + 1'b1;
    end
  end

  // CPU read tracking: the shared RAM register is shown for one cycle after a CPU
  // read, then captured so later dump reads cannot disturb what the CPU sees.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cpu_rd_d <= 1'b0;
      cpu_hold <= '0;
    end else begin
      cpu_rd_d <= cpu_go && i_rd_ram;
      if (cpu_rd_d) cpu_hold <= ram_rdata;
    end
  end

  assign o_data_mem   = cpu_rd_d ? ram_rdata : cpu_hold;
  assign o_dump_valid = (state == ST_SEND);
  assign o_dump_addr  = ptr;
  assign o_dump_data  = (state == ST_SEND) ? ram_rdata : '0;
  assign o_dump_done  = (state == ST_DONE);
  assign o_busy       = is_busy(state);

endmodule
